// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding and default sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_CLR = 2'd3
  } state_e;

  localparam int DEF_DEPTH       = 8;
  localparam int DEF_ACK_CYCLES  = 1;
  localparam int DEF_ACK_TIMEOUT = 16;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side handshake, consumer-side FIFO port and status of the UART receive controller.
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 8
);
  // rx_complete_flag is a level held by the receiver until it sees rx_complete_del_flag;
  // rd_en pops the head whenever the FIFO is non-empty (ignored when empty).
  logic [7:0]              rx_data;
  logic                    rx_complete_flag;
  logic                    rx_complete_del_flag;
  logic                    rd_en;
  logic [7:0]              dout;
  logic                    empty;
  logic                    full;
  logic [$clog2(DEPTH):0]  level;
  logic                    overrun;
  logic                    overrun_clr;
  logic [15:0]             byte_cnt;
  logic [1:0]              dbg_state;

  modport slave (
    input  rx_data, rx_complete_flag, rd_en, overrun_clr,
    output rx_complete_del_flag, dout, empty, full, level, overrun, byte_cnt, dbg_state
  );

  modport master (
    output rx_data, rx_complete_flag, rd_en, overrun_clr,
    input  rx_complete_del_flag, dout, empty, full, level, overrun, byte_cnt, dbg_state
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; head is a combinational read of registered storage.
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [LW-1:0] o_level
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_last;
  logic          w_empty;
  logic          w_full;
  logic          w_do_rd;
  logic          w_do_wr;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_do_rd = i_rd_en && !w_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is legal then.
  assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= 8'h00;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_din;
  end

  // When empty the head slot is stale, so present the last byte popped instead.
  assign o_dout  = w_empty ? r_last : r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = r_level;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures completed bytes into a FWFT FIFO and acknowledges the receiver.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ACK_CYCLES  = DEF_ACK_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input logic           rx_clk,
  input logic           reset_n,
  uart_rx_ctrl_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e        r_state;
  state_e        w_next;
  logic [3:0]    r_ack_cnt;
  logic [TW-1:0] r_wait_cnt;
  logic          r_overrun;
  logic [15:0]   r_byte_cnt;
  logic          w_capture;
  logic          w_ack;
  logic          w_fifo_full;
  logic          w_wr_en;
  logic          w_drop;

  always_ff @(posedge rx_clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_ack     = 1'b0;
    case (r_state)
      ST_IDLE:    if (bus.rx_complete_flag) w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        w_capture = 1'b1;
        w_next    = ST_ACK;
      end
      ST_ACK: begin
        w_ack = 1'b1;
        if (r_ack_cnt == 4'(ACK_CYCLES - 1)) w_next = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        // A flag that never falls gets re-acknowledged, never re-captured.
        if (!bus.rx_complete_flag)                      w_next = ST_IDLE;
        else if (r_wait_cnt == TW'(ACK_TIMEOUT - 1))    w_next = ST_ACK;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  assign w_wr_en = w_capture && (!w_fifo_full || bus.rd_en);
  assign w_drop  = w_capture && !w_wr_en;

  // Dwell counters restart at zero every time their state is entered.
  always_ff @(posedge rx_clk) begin
    if (!reset_n) begin
      r_ack_cnt  <= '0;
      r_wait_cnt <= '0;
      r_overrun  <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      r_ack_cnt  <= (r_state == ST_ACK)      ? r_ack_cnt + 1'b1  : '0;
      r_wait_cnt <= (r_state == ST_WAIT_CLR) ? r_wait_cnt + 1'b1 : '0;
      if (w_drop)               r_overrun <= 1'b1;
      else if (bus.overrun_clr) r_overrun <= 1'b0;
      if (w_wr_en) r_byte_cnt <= r_byte_cnt + 16'd1;
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (rx_clk),
    .i_rst_n (reset_n),
    .i_wr_en (w_wr_en),
    .i_rd_en (bus.rd_en),
    .i_din   (bus.rx_data),
    .o_dout  (bus.dout),
    .o_empty (bus.empty),
    .o_full  (w_fifo_full),
    .o_level (bus.level)
  );

  assign bus.full                 = w_fifo_full;
  assign bus.rx_complete_del_flag = w_ack;
  assign bus.overrun              = r_overrun;
  assign bus.byte_cnt             = r_byte_cnt;
  assign bus.dbg_state            = r_state;

endmodule
